read_burst_engine: RTL and testbench
====================================

# read_burst_engine

Master-side sequencer for the read memory port. Accepts a burst command (base address, word count), issues one single-word read per word on a `ReadMemoryInterface` master modport, buffers the returned words in a small FIFO, and streams them downstream over a valid/ready handshake. It sits directly upstream of any memory slave on that interface and feeds cache-fill and DMA consumers.

## Interface

Parameters:
- `ADDRESS_WIDTH`, 16: memory address width; must match the attached interface.
- `DATA_WIDTH`, 32: memory data width; must match the attached interface.
- `COUNT_WIDTH`, 8: width of the burst word count.
- `FIFO_DEPTH`, 4: output buffer depth in words; power of two, at least 2.
- `TIMEOUT_CYCLES`, 256: watchdog limit. Used only when `READ_BURST_TIMEOUT_EN` is defined.

Ports:
- `clock`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: burst command strobe; sampled only in IDLE.
- `baseAddress`  in  ADDRESS_WIDTH: first word address; captured on accepted `start`.
- `wordCount`  in  COUNT_WIDTH: number of words; captured on accepted `start`.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1: one-cycle completion pulse.
- `dataOut`  out  DATA_WIDTH: FIFO head word.
- `dataValid`  out  1: FIFO is non-empty.
- `dataReady`  in  1: downstream accepts `dataOut` when `dataValid && dataReady`.
- `memory`  `ReadMemoryInterface.master`  port group: `address`, `readEnabled` out; `dataIn`, `functionComplete` in.

## Operation

- States: IDLE, REQUEST, RELEASE, STALL, DRAIN.
- IDLE, `start`=1: capture `baseAddress` into the address register and `wordCount` into the remaining counter. Go to REQUEST if the count is non-zero, otherwise DRAIN.
- REQUEST: drive `readEnabled`=1 with `address` set to the current address. Hold both stable until `functionComplete`=1 is sampled.
- When `functionComplete` is sampled:
  - push `dataIn` into the FIFO;
  - decrement the remaining count;
  - increment the address modulo 2^ADDRESS_WIDTH (0xFFFF wraps to 0x0000);
  - go to RELEASE.
- RELEASE: drive `readEnabled`=0 for exactly one cycle, then:
  - remaining = 0: go to DRAIN;
  - FIFO full: go to STALL;
  - otherwise: go to REQUEST.
- STALL: `readEnabled`=0. Go to REQUEST when the FIFO is not full.
- DRAIN: when the FIFO is empty, pulse `done` and go to IDLE.
- A zero-word burst produces `done` two cycles after `start`, with no memory access.
- A new request is never issued unless the FIFO has room for its word. The FIFO therefore never overflows, and at most one read is outstanding.
- FIFO push and pop may occur in the same cycle, including when the FIFO is full.
- `start` outside IDLE is ignored.
- `functionComplete` outside REQUEST is ignored.
- Reset:
  - forces IDLE and empties the FIFO;
  - all outputs go to 0: `busy`, `done`, `dataValid`, `dataOut`, `memory.readEnabled`, `memory.address`;
  - an in-flight read is abandoned.

## Timing

- `start` accepted at edge 0 → `busy`=1 and `readEnabled`=1 from cycle 1.
- `functionComplete` sampled at edge N:
  - `dataValid`=1 from cycle N+1;
  - `readEnabled`=0 in cycle N+1;
  - next `readEnabled`=1 in cycle N+2 if there is FIFO space.
- With a zero-wait slave, throughput is one word per 2 cycles.
- `done` is asserted in the cycle after DRAIN observes an empty FIFO. `busy` falls one cycle after `done`.

## Configuration

- `READ_BURST_TIMEOUT_EN` defined:
  - a counter runs while in REQUEST;
  - if `functionComplete` is absent for `TIMEOUT_CYCLES` consecutive cycles, drop `readEnabled`, discard the remaining words, and go to DRAIN;
  - the extra output `timeout` (out, 1) pulses for one cycle at abort and resets to 0;
  - already buffered words are still delivered, then `done` pulses.
- `READ_BURST_TIMEOUT_EN` undefined: no counter and no `timeout` port; REQUEST waits indefinitely.

## Test plan

- Burst with base 0x0100, count 3, slave answering in 1 cycle, `dataReady`=1:
  - addresses 0x0100, 0x0101, 0x0102 appear in order;
  - words are delivered in order;
  - `done` pulses exactly once and `busy` then falls.
- Count 0 → no `readEnabled`; `done` 2 cycles after `start`.
- Base 0xFFFE, count 4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `dataReady`=0, count 8, `FIFO_DEPTH`=4:
  - exactly 4 reads, then STALL with `readEnabled`=0;
  - raising `dataReady` resumes the burst;
  - all 8 words are delivered without loss or duplication.
- `reset` asserted while `readEnabled`=1 mid-burst → all outputs are 0 immediately; the next `start` runs cleanly.
- With `READ_BURST_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, slave silent on word 2 of 5:
  - `timeout` pulses;
  - word 1 is delivered;
  - `done` then pulses.

Source files
------------

// File: rtl/read_burst_engine_if.sv
// rtl/read_burst_engine_if.sv - single-word read memory port shared by the burst engine and memory slaves
interface ReadMemoryInterface #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     readEnabled;
    logic [DATA_WIDTH-1:0]    dataIn;
    logic                     functionComplete;

    modport master (
        output address,
        output readEnabled,
        input  dataIn,
        input  functionComplete
    );

    modport slave (
        input  address,
        input  readEnabled,
        output dataIn,
        output functionComplete
    );
endinterface

// File: rtl/read_burst_engine.sv
// rtl/read_burst_engine.sv - burst read sequencer with output FIFO and valid/ready stream
// Optional request watchdog and timeout port enabled by defining READ_BURST_TIMEOUT_EN.
module read_burst_engine #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int COUNT_WIDTH    = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] baseAddress,
    input  logic [COUNT_WIDTH-1:0]   wordCount,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    dataOut,
    output logic                     dataValid,
    input  logic                     dataReady,
`ifdef READ_BURST_TIMEOUT_EN
    output logic                     timeout,
`endif
    ReadMemoryInterface.master       memory
);

    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_WIDTH = PTR_WIDTH + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_config
        $error("read_burst_engine: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        RELEASE,
        STALL,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [COUNT_WIDTH-1:0]   remaining;
    logic                     busy_q;
    logic                     done_q;

    logic [DATA_WIDTH-1:0]    storage [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]     wr_ptr;
    logic [PTR_WIDTH-1:0]     rd_ptr;
    logic [LEVEL_WIDTH-1:0]   fifo_level;
    logic                     fifo_full;
    logic                     fifo_empty;

    logic accept;
    logic push;
    logic pop;
    logic drain_done;
    logic abort;

    assign fifo_full  = (fifo_level == LEVEL_WIDTH'(FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign pop        = !fifo_empty && dataReady;

    assign dataValid = !fifo_empty;
    // Masking the head keeps dataOut at zero after reset without resetting the storage array.
    assign dataOut   = fifo_empty ? '0 : storage[rd_ptr];
    assign busy      = busy_q;
    assign done      = done_q;

    assign memory.address     = address_q;
    assign memory.readEnabled = (state == REQUEST);

`ifdef READ_BURST_TIMEOUT_EN
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_WIDTH-1:0] timer;
    logic                   timer_expired;

    assign timer_expired = (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

    // Counts consecutive REQUEST cycles without a completion; cleared on any exit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= abort;
            if (state == REQUEST && !memory.functionComplete && !abort) begin
                timer <= timer + TIMER_WIDTH'(1);
            end else begin
                timer <= '0;
            end
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        push       = 1'b0;
        drain_done = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (wordCount != '0) ? REQUEST : DRAIN;
                end
            end
            REQUEST: begin
                if (memory.functionComplete) begin
                    push       = 1'b1;
                    state_next = RELEASE;
                end
`ifdef READ_BURST_TIMEOUT_EN
                else if (timer_expired) begin
                    abort      = 1'b1;
                    state_next = DRAIN;
                end
`endif
            end
            RELEASE: begin
                if (remaining == '0) begin
                    state_next = DRAIN;
                end else if (fifo_full) begin
                    state_next = STALL;
                end else begin
                    state_next = REQUEST;
                end
            end
            STALL: begin
                if (!fifo_full) begin
                    state_next = REQUEST;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    drain_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // done is registered one cycle behind the empty check; busy covers the done cycle and drops after it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            address_q <= '0;
            remaining <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= drain_done;
            if (accept) begin
                busy_q <= 1'b1;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end
            if (accept) begin
                address_q <= baseAddress;
                remaining <= wordCount;
            end else if (push) begin
                address_q <= address_q + ADDRESS_WIDTH'(1);
                remaining <= remaining - COUNT_WIDTH'(1);
            end else if (abort) begin
                remaining <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            storage[wr_ptr] <= memory.dataIn;
        end
    end

    // A push only happens from REQUEST, which is entered only with room, so no overflow guard is needed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_WIDTH'(1);
                2'b01:   fifo_level <= fifo_level - LEVEL_WIDTH'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule

// File: tb/tb_read_burst_engine.sv
// tb/tb_read_burst_engine.sv - randomized scoreboard bench for read_burst_engine
module tb_read_burst_engine;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] baseAddress;
    logic [7:0]  wordCount;
    logic        busy;
    logic        done;
    logic [31:0] dataOut;
    logic        dataValid;
    logic        dataReady;
`ifdef READ_BURST_TIMEOUT_EN
    logic        timeout;
`endif

    ReadMemoryInterface #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) mem_if ();

    read_burst_engine #(
        .ADDRESS_WIDTH (16),
        .DATA_WIDTH    (32),
        .COUNT_WIDTH   (8),
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .baseAddress(baseAddress),
        .wordCount  (wordCount),
        .busy       (busy),
        .done       (done),
        .dataOut    (dataOut),
        .dataValid  (dataValid),
        .dataReady  (dataReady),
`ifdef READ_BURST_TIMEOUT_EN
        .timeout    (timeout),
`endif
        .memory     (mem_if)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] exp_addrs [$];
    logic [31:0] exp_words [$];

    logic [31:0] salt = 32'h0;
    int          lat = 0;
    int          rdy_mode = 0;
    bit          silent_en = 1'b0;
    logic [15:0] silent_addr = 16'h0;
    int          done_cnt = 0;
    int          req_cnt = 0;
    int          timeout_cnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return {~a, a} ^ salt;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory slave: answers each request after a random 0..lat cycle wait.
    initial begin
        int wait_ctr;
        wait_ctr = -1;
        mem_if.functionComplete = 1'b0;
        mem_if.dataIn = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            mem_if.functionComplete = 1'b0;
            if (reset || !mem_if.readEnabled) begin
                wait_ctr = -1;
            end else if (!(silent_en && mem_if.address == silent_addr)) begin
                if (wait_ctr < 0) wait_ctr = int'($urandom_range(0, lat));
                if (wait_ctr == 0) begin
                    mem_if.functionComplete = 1'b1;
                    mem_if.dataIn = word_of(mem_if.address);
                    wait_ctr = -1;
                end else begin
                    wait_ctr--;
                end
            end
        end
    end

    initial begin
        dataReady = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0:       dataReady = 1'b1;
                1:       dataReady = ($urandom_range(0, 3) != 0);
                default: dataReady = 1'b0;
            endcase
        end
    end

    // Monitor: compares requests and delivered words against the scoreboard queues.
    initial begin
        bit          re_prev;
        int          occ;
        logic [15:0] held;
        re_prev = 1'b0;
        occ = 0;
        held = 16'h0;
        forever begin
            @(negedge clock);
            if (reset) begin
                re_prev = 1'b0;
                occ = 0;
            end else begin
                if (mem_if.readEnabled && !re_prev) begin
                    req_cnt++;
                    held = mem_if.address;
                    check("room_at_request", occ < 4, 1);
                    if (exp_addrs.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_request: got %0h expected none", mem_if.address);
                    end else begin
                        check("request_address", mem_if.address, exp_addrs.pop_front());
                    end
                end else if (mem_if.readEnabled) begin
                    check("address_stable", mem_if.address, held);
                end
                if (dataValid && dataReady) begin
                    if (exp_words.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_word: got %0h expected none", dataOut);
                    end else begin
                        check("delivered_word", dataOut, exp_words.pop_front());
                    end
                end
                if (done) done_cnt++;
`ifdef READ_BURST_TIMEOUT_EN
                if (timeout) timeout_cnt++;
`endif
                occ = occ + int'(mem_if.readEnabled && mem_if.functionComplete) - int'(dataValid && dataReady);
                re_prev = mem_if.readEnabled;
            end
        end
    end

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1);
    endtask

    task automatic run_burst(input logic [15:0] base, input int cnt, input int lat_max, input int mode,
                             input bit poke, input bit stall_chk, input bit silent);
        int n_req;
        int n_words;
        salt = $urandom;
        lat = lat_max;
        rdy_mode = mode;
        silent_en = silent;
        silent_addr = base + 16'd1;
        n_req = silent ? 2 : cnt;
        n_words = silent ? 1 : cnt;
        for (int i = 0; i < n_req; i++) exp_addrs.push_back(base + 16'(i));
        for (int i = 0; i < n_words; i++) exp_words.push_back(word_of(base + 16'(i)));
        done_cnt = 0;
        req_cnt = 0;
        timeout_cnt = 0;
        @(posedge clock);
        #1;
        start = 1'b1;
        baseAddress = base;
        wordCount = 8'(cnt);
        @(posedge clock);
        #1;
        start = 1'b0;
        baseAddress = 16'($urandom);
        wordCount = 8'($urandom);
        @(negedge clock);
        check("busy_after_start", busy, 1);
        check("read_after_start", mem_if.readEnabled, cnt != 0);
        if (cnt == 0) begin
            @(negedge clock);
            check("zero_burst_done_latency", done, 1);
        end else begin
            if (poke) begin
                @(posedge clock);
                #1;
                start = 1'b1;
                baseAddress = 16'($urandom);
                wordCount = 8'd1;
                @(posedge clock);
                #1;
                start = 1'b0;
            end
            if (stall_chk) begin
                repeat (40) @(negedge clock);
                check("stall_read_count", req_cnt, 4);
                check("stall_read_low", mem_if.readEnabled, 0);
                check("stall_data_valid", dataValid, 1);
                rdy_mode = 0;
            end
            wait_done();
        end
        @(negedge clock);
        #1;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("done_pulse_count", done_cnt, 1);
        check("request_count", req_cnt, n_req);
        check("addresses_left", exp_addrs.size(), 0);
        check("words_left", exp_words.size(), 0);
`ifdef READ_BURST_TIMEOUT_EN
        check("timeout_pulses", timeout_cnt, silent ? 1 : 0);
`endif
        silent_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        baseAddress = 16'h0;
        wordCount = 8'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", dataValid, 0);
        check("reset_data", dataOut, 0);
        check("reset_read", mem_if.readEnabled, 0);
        check("reset_address", mem_if.address, 0);
        reset = 1'b0;

        run_burst(16'h0100, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        run_burst(16'h0200, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_burst(16'hFFFE, 4, 0, 0, 1'b0, 1'b0, 1'b0);
        run_burst(16'h0400, 8, 0, 2, 1'b0, 1'b1, 1'b0);
        for (int b = 0; b < 8; b++) begin
            run_burst(16'($urandom), int'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        end

        // Reset in the middle of a burst while a read is outstanding.
        salt = $urandom;
        lat = 2;
        rdy_mode = 1;
        req_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            exp_addrs.push_back(16'h3000 + 16'(i));
            exp_words.push_back(word_of(16'h3000 + 16'(i)));
        end
        @(posedge clock);
        #1;
        start = 1'b1;
        baseAddress = 16'h3000;
        wordCount = 8'd6;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 0; i < 100 && !(req_cnt >= 2 && mem_if.readEnabled); i++) @(negedge clock);
        check("midburst_read_active", mem_if.readEnabled, 1);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_valid", dataValid, 0);
        check("midreset_data", dataOut, 0);
        check("midreset_read", mem_if.readEnabled, 0);
        check("midreset_address", mem_if.address, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_addrs.delete();
        exp_words.delete();
        run_burst(16'h3000, 5, 1, 0, 1'b0, 1'b0, 1'b0);

`ifdef READ_BURST_TIMEOUT_EN
        run_burst(16'h0500, 5, 0, 0, 1'b0, 1'b0, 1'b1);
`endif
        run_burst(16'h0600, 2, 0, 1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_watchdog: simulation did not complete, %0d miscompares so far", miscompares);
        $fatal(1);
    end

endmodule
